// File: rtl/tuner_pkg.sv
// Shared types, tables and defaults for the pitch detector and its note classifier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tuner_pkg;

    // Parameter defaults for a 48 kHz sample stream
    localparam int HYST_DEF       = 4096;
    localparam int MIN_PERIOD_DEF = 24;
    localparam int MAX_PERIOD_DEF = 2400;
    localparam int TOL_DEF        = 2;

    localparam int PERIOD_W  = 16;
    localparam int SUM_W     = 18;
    localparam int NUM_NOTES = 8;

    typedef logic [PERIOD_W-1:0] period_t;
    typedef logic [2:0]          note_t;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

    // Classifiable period window (samples)
    localparam period_t RANGE_LO = 16'd87;
    localparam period_t RANGE_HI = 16'd193;

    // Nominal periods for C4 D4 E4 F4 G4 A4 B4 C5
    localparam period_t NOMINAL_TBL [NUM_NOTES] = '{
        16'd183, 16'd163, 16'd146, 16'd137, 16'd122, 16'd109, 16'd97, 16'd92
    };

    // Midpoints between neighbouring nominals; period >= BOUNDARY_TBL[i] selects note i
    localparam period_t BOUNDARY_TBL [NUM_NOTES-1] = '{
        16'd173, 16'd154, 16'd141, 16'd129, 16'd115, 16'd103, 16'd94
    };

endpackage

// File: rtl/note_classifier.sv
// Maps an averaged period to nearest note index with flat/sharp tuning flags.
// Latency: combinational; the parent registers the outputs.
// Backpressure: none.
// Ports: i_period (samples) -> o_note, o_note_valid (in classifiable window),
//        o_flat (period above nominal+TOL), o_sharp (period below nominal-TOL).
module note_classifier
    import tuner_pkg::*;
#(
    parameter int TOL = TOL_DEF
) (
    input  logic [PERIOD_W-1:0] i_period,
    output logic [2:0]          o_note,
    output logic                o_note_valid,
    output logic                o_flat,
    output logic                o_sharp
);

    localparam period_t TOL_P = period_t'(TOL);

    note_t   w_note;
    period_t w_nom;
    logic    w_in_range;

    always_comb begin
        w_note = 3'd7;
        // Boundaries descend, so the lowest index whose boundary is met wins
        for (int i = NUM_NOTES - 2; i >= 0; i--) begin
            if (i_period >= BOUNDARY_TBL[i]) begin
                w_note = 3'(i);
            end
        end
        w_nom      = NOMINAL_TBL[w_note];
        w_in_range = (i_period >= RANGE_LO) && (i_period <= RANGE_HI);

        o_note       = w_note;
        o_note_valid = w_in_range;
        o_flat       = w_in_range && (i_period > (w_nom + TOL_P));
        o_sharp      = w_in_range && (i_period < (w_nom - TOL_P));
    end

endmodule

// File: rtl/pitch_detector.sv
// Hysteretic zero-crossing pitch detector: averages four periods and classifies to a note.
// Latency: results register one clock after the sample carrying the 4th accepted crossing.
// Backpressure: none; samples are consumed whenever enable and sample_valid are high.
// Ports: clk/reset (sync, active-high); enable, sample_valid, sample_in[23:0] (signed);
//        period_out, result_valid, note_out, note_valid, flat, sharp, signal_present.
module pitch_detector
    import tuner_pkg::*;
#(
    parameter int HYST       = HYST_DEF,
    parameter int MIN_PERIOD = MIN_PERIOD_DEF,
    parameter int MAX_PERIOD = MAX_PERIOD_DEF,
    parameter int TOL        = TOL_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        sample_valid,
    input  logic [23:0] sample_in,
    output logic [15:0] period_out,
    output logic        result_valid,
    output logic [2:0]  note_out,
    output logic        note_valid,
    output logic        flat,
    output logic        sharp,
    output logic        signal_present
);

    localparam logic signed [23:0] HYST_POS = 24'(HYST);
    localparam logic signed [23:0] HYST_NEG = -HYST_POS;
    localparam period_t            MIN_P    = period_t'(MIN_PERIOD);
    localparam period_t            MAX_P    = period_t'(MAX_PERIOD);

    state_t             r_state;
    logic               r_armed;
    period_t            r_cnt;
    logic [1:0]         r_nper;
    logic [SUM_W-1:0]   r_sum;
    period_t            r_period;
    note_t              r_note;
    logic               r_note_valid;
    logic               r_flat;
    logic               r_sharp;
    logic               r_result_valid;
    logic               r_sig_present;

    state_t             w_nxt_state;
    logic               w_nxt_armed;
    period_t            w_nxt_cnt;
    logic [1:0]         w_nxt_nper;
    logic [SUM_W-1:0]   w_nxt_sum;
    logic               w_done;
    logic               w_timeout;
    period_t            w_avg;

    logic signed [23:0] w_smp;
    logic               w_neg;
    logic               w_cross;
    period_t            w_cnt_inc;
    logic [SUM_W-1:0]   w_sum_tot;

    note_t              w_cls_note;
    logic               w_cls_valid;
    logic               w_cls_flat;
    logic               w_cls_sharp;

    assign w_smp     = signed'(sample_in);
    assign w_neg     = (w_smp <= HYST_NEG);
    assign w_cross   = r_armed && (w_smp >= HYST_POS);
    // The period of a crossing includes the crossing sample itself
    assign w_cnt_inc = r_cnt + 16'd1;
    assign w_sum_tot = r_sum + {{(SUM_W-PERIOD_W){1'b0}}, w_cnt_inc};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_armed <= 1'b0;
            r_cnt   <= '0;
            r_nper  <= '0;
            r_sum   <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_armed <= w_nxt_armed;
            r_cnt   <= w_nxt_cnt;
            r_nper  <= w_nxt_nper;
            r_sum   <= w_nxt_sum;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_armed = r_armed;
        w_nxt_cnt   = r_cnt;
        w_nxt_nper  = r_nper;
        w_nxt_sum   = r_sum;
        w_done      = 1'b0;
        w_timeout   = 1'b0;
        w_avg       = w_sum_tot[SUM_W-1:2];

        if (!enable) begin
            w_nxt_state = ST_IDLE;
            w_nxt_armed = 1'b0;
            w_nxt_cnt   = '0;
            w_nxt_nper  = '0;
            w_nxt_sum   = '0;
        end else if (sample_valid) begin
            // Arm on a deep negative excursion; a crossing consumes the arm,
            // including crossings later discarded as glitches
            if (w_neg) begin
                w_nxt_armed = 1'b1;
            end else if (w_cross) begin
                w_nxt_armed = 1'b0;
            end

            unique case (r_state)
                ST_IDLE: begin
                    if (w_cross) begin
                        w_nxt_state = ST_MEASURE;
                        w_nxt_cnt   = '0;
                        w_nxt_nper  = '0;
                        w_nxt_sum   = '0;
                    end
                end
                ST_MEASURE: begin
                    if (w_cnt_inc >= MAX_P) begin
                        w_nxt_state = ST_IDLE;
                        w_nxt_armed = 1'b0;
                        w_nxt_cnt   = '0;
                        w_nxt_nper  = '0;
                        w_nxt_sum   = '0;
                        w_timeout   = 1'b1;
                    end else if (w_cross && (w_cnt_inc >= MIN_P)) begin
                        w_nxt_cnt = '0;
                        if (r_nper == 2'd3) begin
                            w_nxt_nper = '0;
                            w_nxt_sum  = '0;
                            w_done     = 1'b1;
                        end else begin
                            w_nxt_nper = r_nper + 2'd1;
                            w_nxt_sum  = w_sum_tot;
                        end
                    end else begin
                        // Normal sample or a too-short glitch crossing
                        w_nxt_cnt = w_cnt_inc;
                    end
                end
                default: w_nxt_state = ST_IDLE;
            endcase
        end
    end

    note_classifier #(
        .TOL (TOL)
    ) u_note_classifier (
        .i_period     (w_avg),
        .o_note       (w_cls_note),
        .o_note_valid (w_cls_valid),
        .o_flat       (w_cls_flat),
        .o_sharp      (w_cls_sharp)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_period       <= '0;
            r_note         <= '0;
            r_note_valid   <= 1'b0;
            r_flat         <= 1'b0;
            r_sharp        <= 1'b0;
            r_result_valid <= 1'b0;
            r_sig_present  <= 1'b0;
        end else begin
            r_result_valid <= w_done;
            if (w_done) begin
                r_period      <= w_avg;
                r_note_valid  <= w_cls_valid;
                r_flat        <= w_cls_flat;
                r_sharp       <= w_cls_sharp;
                r_sig_present <= 1'b1;
                // Out-of-range averages leave the last classified note in place
                if (w_cls_valid) begin
                    r_note <= w_cls_note;
                end
            end else if (w_timeout) begin
                r_sig_present <= 1'b0;
            end
        end
    end

    assign period_out     = r_period;
    assign result_valid   = r_result_valid;
    assign note_out       = r_note;
    assign note_valid     = r_note_valid;
    assign flat           = r_flat;
    assign sharp          = r_sharp;
    assign signal_present = r_sig_present;

endmodule

// File: tb/tb_pitch_detector.sv
// Directed testbench for pitch_detector with hand-computed expectations.
// Latency: n/a.
// Backpressure: n/a.
module tb_pitch_detector;

    localparam int AMP  = 768000;   // 0x0BB800
    localparam int HYST = 4096;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        sample_valid = 1'b0;
    logic [23:0] sample_in = '0;
    logic [15:0] period_out;
    logic        result_valid;
    logic [2:0]  note_out;
    logic        note_valid;
    logic        flat;
    logic        sharp;
    logic        signal_present;

    int n_cmp = 0;
    int n_err = 0;
    int rv_cnt = 0;
    int rv_base;

    pitch_detector dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .sample_valid   (sample_valid),
        .sample_in      (sample_in),
        .period_out     (period_out),
        .result_valid   (result_valid),
        .note_out       (note_out),
        .note_valid     (note_valid),
        .flat           (flat),
        .sharp          (sharp),
        .signal_present (signal_present)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (result_valid) rv_cnt++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send(input int s);
        @(negedge clk);
        sample_valid = 1'b1;
        sample_in    = 24'(s);
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b1;
        sample_valid = 1'b0;
        @(negedge clk);
        reset        = 1'b0;
    endtask

    // n cycles of lo negative samples followed by hi positive samples
    task automatic square(input int lo, input int hi, input int n);
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < lo; i++) send(-AMP);
            for (int i = 0; i < hi; i++) send(AMP);
        end
    endtask

    task automatic chk_result(input string tag, input int exp_rv, input int per,
                              input int note, input int nv, input int fl, input int sh);
        chk({tag, "_rv"},    rv_cnt - rv_base, exp_rv);
        chk({tag, "_per"},   int'(period_out), per);
        chk({tag, "_note"},  int'(note_out), note);
        chk({tag, "_nv"},    int'(note_valid), nv);
        chk({tag, "_flat"},  int'(flat), fl);
        chk({tag, "_sharp"}, int'(sharp), sh);
    endtask

    initial begin
        do_reset();
        @(negedge clk);
        // Reset state
        chk("rst_per",   int'(period_out), 0);
        chk("rst_note",  int'(note_out), 0);
        chk("rst_nv",    int'(note_valid), 0);
        chk("rst_flat",  int'(flat), 0);
        chk("rst_sharp", int'(sharp), 0);
        chk("rst_rv",    int'(result_valid), 0);
        chk("rst_sp",    int'(signal_present), 0);
        enable = 1'b1;

        // 109-sample square wave (A4); check exact pulse timing on the 5th crossing
        rv_base = rv_cnt;
        square(54, 55, 4);
        for (int i = 0; i < 54; i++) send(-AMP);
        chk("a4_rv_early", rv_cnt - rv_base, 0);
        send(AMP);
        chk("a4_rv_pulse", int'(result_valid), 1);
        chk("a4_sp",       int'(signal_present), 1);
        @(negedge clk);
        chk("a4_rv_one",   int'(result_valid), 0);
        for (int i = 0; i < 54; i++) send(AMP);
        chk_result("a4", 1, 109, 5, 1, 0, 0);

        // Sub-hysteresis sine: no crossings
        do_reset();
        rv_base = rv_cnt;
        for (int i = 0; i < 300; i++)
            send($rtoi(2000.0 * $sin(2.0 * 3.14159265 * i / 100.0)));
        chk("sine_rv", rv_cnt - rv_base, 0);
        chk("sine_sp", int'(signal_present), 0);

        // Period 188 -> C4, flat
        do_reset();
        rv_base = rv_cnt;
        square(94, 94, 5);
        chk_result("p188", 1, 188, 0, 1, 1, 0);

        // Period 90 -> C5, within tolerance
        do_reset();
        rv_base = rv_cnt;
        square(45, 45, 5);
        chk_result("p90", 1, 90, 7, 1, 0, 0);

        // Disable clears the measurement but holds outputs
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("dis_per_hold", int'(period_out), 90);
        enable = 1'b1;

        // Period 300 -> out of range, note held at 7
        rv_base = rv_cnt;
        square(150, 150, 5);
        chk_result("p300", 1, 300, 7, 0, 0, 0);

        // Timeout: signal held until counter reaches MAX_PERIOD
        do_reset();
        rv_base = rv_cnt;
        square(54, 55, 5);
        chk("to_sp_set", int'(signal_present), 1);
        for (int i = 0; i < 2345; i++) send(0);
        chk("to_sp_before", int'(signal_present), 1);
        send(0);
        chk("to_sp_after", int'(signal_present), 0);
        chk_result("to_hold", 1, 109, 5, 1, 0, 0);
        square(54, 55, 2);
        chk("to_no_rv", rv_cnt - rv_base, 1);

        // Glitch: -HYST then +HYST at samples 9/10 of the high phase
        do_reset();
        rv_base = rv_cnt;
        for (int c = 0; c < 5; c++) begin
            for (int i = 0; i < 54; i++) send(-AMP);
            for (int i = 0; i < 55; i++) begin
                if ((c == 1 || c == 2) && i == 9)       send(-HYST);
                else if ((c == 1 || c == 2) && i == 10) send(HYST);
                else                                    send(AMP);
            end
        end
        chk_result("glitch", 1, 109, 5, 1, 0, 0);

        // Truncating average: periods 110,110,110,109 -> 439>>2 = 109
        do_reset();
        rv_base = rv_cnt;
        square(54, 55, 1);
        square(55, 55, 3);
        square(54, 55, 1);
        chk_result("trunc", 1, 109, 5, 1, 0, 0);

        // Reset after two accepted periods of a new group
        do_reset();
        rv_base = rv_cnt;
        square(54, 55, 5);
        square(54, 55, 2);
        do_reset();
        @(negedge clk);
        chk("mrst_per",  int'(period_out), 0);
        chk("mrst_note", int'(note_out), 0);
        chk("mrst_nv",   int'(note_valid), 0);
        chk("mrst_sp",   int'(signal_present), 0);
        rv_base = rv_cnt;
        square(54, 55, 4);
        chk("mrst_no_rv", rv_cnt - rv_base, 0);
        square(54, 55, 1);
        chk_result("mrst", 1, 109, 5, 1, 0, 0);

        // Boundary 173 -> C4 (nominal 183), sharp
        do_reset();
        rv_base = rv_cnt;
        square(86, 87, 5);
        chk_result("p173", 1, 173, 0, 1, 0, 1);

        // Lower range limit 87 -> C5 (nominal 92), sharp
        do_reset();
        rv_base = rv_cnt;
        square(43, 44, 5);
        chk_result("p87", 1, 87, 7, 1, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
